// File: rtl/video_modes_pkg.sv
// Shared definitions for the multi-mode video timing generator: mode
// encodings, the per-mode timing table, sync polarity and FSM states.
package video_modes_pkg;

    localparam int TW = 12;

    localparam logic [1:0] MODE_640X480   = 2'd0;
    localparam logic [1:0] MODE_1280X720  = 2'd1;
    localparam logic [1:0] MODE_1920X1080 = 2'd2;

    localparam logic POL_POS = 1'b1;
    localparam logic POL_NEG = 1'b0;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_PEND      = 2'd1,
        ST_MUTE      = 2'd2,
        ST_MUTE_PEND = 2'd3
    } vt_state_e;

    // Totals and porch/sync widths; active width is what remains.
    typedef struct packed {
        logic [TW-1:0] h_total;
        logic [TW-1:0] h_fp;
        logic [TW-1:0] h_sync;
        logic [TW-1:0] h_bp;
        logic [TW-1:0] v_total;
        logic [TW-1:0] v_fp;
        logic [TW-1:0] v_sync;
        logic [TW-1:0] v_bp;
        logic          pos_pol;
    } timing_t;

    typedef timing_t [2:0] timing_tbl_t;

    function automatic timing_t mk_timing(input int ht, input int hfp, input int hs, input int hbp,
                                          input int vt, input int vfp, input int vs, input int vbp,
                                          input logic pol);
        timing_t t;
        t.h_total = TW'(ht);
        t.h_fp    = TW'(hfp);
        t.h_sync  = TW'(hs);
        t.h_bp    = TW'(hbp);
        t.v_total = TW'(vt);
        t.v_fp    = TW'(vfp);
        t.v_sync  = TW'(vs);
        t.v_bp    = TW'(vbp);
        t.pos_pol = pol;
        return t;
    endfunction

    // Index 0 is the least significant element of the packed table.
    localparam timing_tbl_t VM_TABLE = {
        mk_timing(2200, 88, 44, 148, 1125, 4, 5, 36, POL_POS),
        mk_timing(1650, 110, 40, 220, 750, 5, 5, 20, POL_POS),
        mk_timing(800, 16, 96, 48, 525, 10, 2, 33, POL_NEG)
    };

    // Mode 3 has no timing of its own and runs as 720p.
    function automatic logic [1:0] coerce_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_1280X720 : m;
    endfunction

    function automatic timing_t timing_of(input timing_tbl_t tbl, input logic [1:0] m);
        case (m)
            MODE_640X480:   return tbl[0];
            MODE_1920X1080: return tbl[2];
            default:        return tbl[1];
        endcase
    endfunction

endpackage

// File: rtl/video_timing_multi_sig_delay.sv
// Fixed-depth shift register with an async reset to a chosen value;
// depth 0 is a straight wire.
module sig_delay #(
    parameter int             W       = 1,
    parameter int             DEPTH   = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;
            assign dout = din;
        end else begin : g_pipe
            logic [DEPTH-1:0][W-1:0] stg;
            // Shift one stage per clock; reset parks every stage at RST_VAL.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stg <= {DEPTH{RST_VAL}};
                end else begin
                    stg[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
                end
            end
            assign dout = stg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing_multi.sv
// Multi-mode raster timing generator. Mode changes are deferred to the
// frame end and the first frame of a new mode is blanked (de held low).
module video_timing_multi
    import video_modes_pkg::*;
#(
    parameter int          CW           = 12,
    parameter int          PIPE_DLY     = 2,
    parameter logic [1:0]  DEFAULT_MODE = 2'd1,
    parameter timing_tbl_t MODE_TBL     = VM_TABLE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    mode_sel,
    input  logic          mode_req,
    output logic          mode_ack,
    output logic [1:0]    cur_mode,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          frame_start,
    output logic          line_start,
    output logic          hsync_d,
    output logic          vsync_d,
    output logic          de_d,
    output logic          frame_start_d
);

    localparam logic [1:0] RST_MODE = coerce_mode(DEFAULT_MODE);
    localparam timing_t    RST_T    = timing_of(MODE_TBL, RST_MODE);
    localparam logic       RST_SYNC = ~RST_T.pos_pol;
    localparam logic [CW-1:0] ONE   = CW'(1);

    vt_state_e     state, state_nxt;
    logic [1:0]    pend_mode, pend_nxt;
    logic          load, muted;
    timing_t       tm;
    logic [CW-1:0] h_total, h_active, hs_start, hs_end;
    logic [CW-1:0] v_total, v_active, vs_start, vs_end;
    logic          line_end, frame_end, h_in_sync, v_in_sync;

    assign tm       = timing_of(MODE_TBL, cur_mode);
    assign h_total  = CW'(tm.h_total);
    assign h_active = CW'(tm.h_total - tm.h_fp - tm.h_sync - tm.h_bp);
    assign hs_start = h_active + CW'(tm.h_fp);
    assign hs_end   = hs_start + CW'(tm.h_sync);
    assign v_total  = CW'(tm.v_total);
    assign v_active = CW'(tm.v_total - tm.v_fp - tm.v_sync - tm.v_bp);
    assign vs_start = v_active + CW'(tm.v_fp);
    assign vs_end   = vs_start + CW'(tm.v_sync);

    assign line_end  = (hcount == h_total - ONE);
    assign frame_end = line_end && (vcount == v_total - ONE);

    // Raster counters; the frame-end wrap doubles as the reset to 0 on a mode load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (line_end) begin
            hcount <= '0;
            vcount <= (vcount == v_total - ONE) ? '0 : vcount + ONE;
        end else begin
            hcount <= hcount + ONE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_MUTE;
        else       state <= state_nxt;
    end

    // Next state: requests latch immediately (latest wins), loads only at frame end.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend_mode;
        load      = 1'b0;
        if (mode_req) pend_nxt = coerce_mode(mode_sel);
        if (frame_end) begin
            case (state)
                ST_RUN:  state_nxt = mode_req ? ST_PEND : ST_RUN;
                ST_MUTE: state_nxt = mode_req ? ST_MUTE_PEND : ST_RUN;
                default: begin
                    load      = 1'b1;
                    state_nxt = mode_req ? ST_MUTE_PEND : ST_MUTE;
                end
            endcase
        end else if (mode_req) begin
            case (state)
                ST_RUN:  state_nxt = ST_PEND;
                ST_MUTE: state_nxt = ST_MUTE_PEND;
                default: state_nxt = state;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        muted = (state == ST_MUTE) || (state == ST_MUTE_PEND);
    end

    // Pending/current mode and the acknowledge pulse on the first cycle of a new mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_mode <= '0;
            cur_mode  <= RST_MODE;
            mode_ack  <= 1'b0;
        end else begin
            pend_mode <= pend_nxt;
            mode_ack  <= load;
            if (load) cur_mode <= pend_mode;
        end
    end

    // Same-cycle decode of syncs, data enable and start markers.
    always_comb begin
        h_in_sync   = (hcount >= hs_start) && (hcount < hs_end);
        v_in_sync   = (vcount >= vs_start) && (vcount < vs_end);
        hsync       = tm.pos_pol ? h_in_sync : ~h_in_sync;
        vsync       = tm.pos_pol ? v_in_sync : ~v_in_sync;
        de          = (hcount < h_active) && (vcount < v_active) && !muted;
        line_start  = !reset && (hcount == '0);
        frame_start = !reset && (hcount == '0) && (vcount == '0);
    end

    sig_delay #(
        .W       (4),
        .DEPTH   (PIPE_DLY),
        .RST_VAL ({RST_SYNC, RST_SYNC, 2'b00})
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .din   ({hsync, vsync, de, frame_start}),
        .dout  ({hsync_d, vsync_d, de_d, frame_start_d})
    );

endmodule

// File: tb/tb_video_timing_multi.sv
// Randomised + directed bench. DUT A runs a shrunken timing table against a
// frame-level reference model; DUT B runs the real table for one line+.
module tb_video_timing_multi;
    import video_modes_pkg::*;

    localparam int PD = 3;
    localparam timing_tbl_t SMALL_TBL = {
        mk_timing(36, 2, 5, 4, 14, 2, 1, 3, 1'b1),
        mk_timing(30, 3, 4, 5, 12, 1, 1, 2, 1'b1),
        mk_timing(28, 2, 3, 3, 10, 1, 2, 1, 1'b0)
    };

    // Model copy of the shrunken table, indexed by mode.
    int HT[3]  = '{28, 30, 36};
    int HFP[3] = '{2, 3, 2};
    int HSW[3] = '{3, 4, 5};
    int HBP[3] = '{3, 5, 4};
    int VT[3]  = '{10, 12, 14};
    int VFP[3] = '{1, 1, 2};
    int VSW[3] = '{2, 1, 1};
    int VBP[3] = '{1, 2, 3};
    bit POS[3] = '{1'b0, 1'b1, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A ----------------
    logic reset = 1'b0;
    logic [1:0] mode_sel = 2'd0;
    logic mode_req = 1'b0;
    logic mode_ack, hsync, vsync, de, frame_start, line_start;
    logic hsync_d, vsync_d, de_d, frame_start_d;
    logic [1:0] cur_mode;
    logic [11:0] hcount, vcount;

    video_timing_multi #(.CW(12), .PIPE_DLY(PD), .DEFAULT_MODE(2'd1), .MODE_TBL(SMALL_TBL)) dut (
        .clk(clk), .reset(reset), .mode_sel(mode_sel), .mode_req(mode_req),
        .mode_ack(mode_ack), .cur_mode(cur_mode), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start),
        .line_start(line_start), .hsync_d(hsync_d), .vsync_d(vsync_d),
        .de_d(de_d), .frame_start_d(frame_start_d));

    logic [35:0] dut_vec;
    assign dut_vec = {hcount, vcount, cur_mode, mode_ack, hsync, vsync, de, frame_start,
                      line_start, hsync_d, vsync_d, de_d, frame_start_d};

    // ---------------- DUT B (real table, no delay) ----------------
    logic rst_b = 1'b0;
    logic [1:0] sel_b = 2'd0;
    logic req_b = 1'b0;
    logic ack_b, hs_b, vs_b, de_b, fs_b, ls_b, hsd_b, vsd_b, ded_b, fsd_b;
    logic [1:0] mode_b;
    logic [11:0] hc_b, vc_b;

    video_timing_multi #(.CW(12), .PIPE_DLY(0), .DEFAULT_MODE(2'd1)) dut_b (
        .clk(clk), .reset(rst_b), .mode_sel(sel_b), .mode_req(req_b),
        .mode_ack(ack_b), .cur_mode(mode_b), .hcount(hc_b), .vcount(vc_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .frame_start(fs_b),
        .line_start(ls_b), .hsync_d(hsd_b), .vsync_d(vsd_b),
        .de_d(ded_b), .frame_start_d(fsd_b));

    logic [35:0] dut_b_vec;
    assign dut_b_vec = {hc_b, vc_b, mode_b, ack_b, hs_b, vs_b, de_b, fs_b,
                        ls_b, hsd_b, vsd_b, ded_b, fsd_b};

    int n_pass = 0, n_total = 0;
    bit b_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // ---------------- reference model ----------------
    int  m_h, m_v, m_mode, m_pval, cyc;
    bit  m_muted, m_pv, m_ack, m_rst;
    bit  pin_on = 1'b0;
    logic [3:0] dq[$];

    function automatic logic [3:0] und();
        int ha, va;
        bit hw, vw, hs, vs, d, fs;
        ha = HT[m_mode] - HFP[m_mode] - HSW[m_mode] - HBP[m_mode];
        va = VT[m_mode] - VFP[m_mode] - VSW[m_mode] - VBP[m_mode];
        hw = (m_h >= ha + HFP[m_mode]) && (m_h < ha + HFP[m_mode] + HSW[m_mode]);
        vw = (m_v >= va + VFP[m_mode]) && (m_v < va + VFP[m_mode] + VSW[m_mode]);
        hs = POS[m_mode] ? hw : !hw;
        vs = POS[m_mode] ? vw : !vw;
        d  = (m_h < ha) && (m_v < va) && !m_muted;
        fs = (m_h == 0) && (m_v == 0) && !m_rst;
        return {hs, vs, d, fs};
    endfunction

    function automatic logic [35:0] exp_vec();
        return {12'(m_h), 12'(m_v), 2'(m_mode), m_ack, und(), (m_h == 0) && !m_rst, dq[0]};
    endfunction

    function automatic bit at_fe();
        return (m_h == HT[m_mode] - 1) && (m_v == VT[m_mode] - 1);
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = 0; m_mode = 1; m_muted = 1'b1; m_pv = 1'b0; m_ack = 1'b0;
        m_pval = 0;
        dq.delete();
        repeat (PD) dq.push_back(4'b0000);
    endtask

    // One clock edge: what the frame-level rules say happens.
    task automatic model_adv(input bit req, input logic [1:0] sel);
        logic [3:0] u;
        bit fe, apply;
        u = und();
        dq.push_back(u);
        u = dq.pop_front();
        fe = at_fe();
        if (m_h == HT[m_mode] - 1) begin
            m_h = 0;
            m_v = (m_v == VT[m_mode] - 1) ? 0 : m_v + 1;
        end else begin
            m_h++;
        end
        m_ack = 1'b0;
        if (fe) begin
            apply = m_pv;
            m_muted = apply || (m_muted && req);
            if (apply) begin
                m_mode = m_pval;
                m_ack = 1'b1;
                m_pv = 1'b0;
            end
        end
        if (req) begin
            m_pv = 1'b1;
            m_pval = (sel == 2'd3) ? 1 : int'(sel);
        end
        cyc++;
    endtask

    // Hand-computed points after reset in mode 1 of the small table (frame = 360 clocks).
    task automatic pins();
        case (cyc)
            100: chk("pin_first_frame_de", de, 1'b0);
            360: begin chk("pin_fs_frame2", frame_start, 1'b1); chk("pin_de_frame2", de, 1'b1); end
            362: chk("pin_de_d_before", de_d, 1'b0);
            363: chk("pin_de_d_3clk", de_d, 1'b1);
            377: chk("pin_de_last_px", de, 1'b1);
            378: chk("pin_de_after_active", de, 1'b0);
            380: chk("pin_hs_before", hsync, 1'b0);
            381: chk("pin_hs_first", hsync, 1'b1);
            384: chk("pin_hs_last", hsync, 1'b1);
            385: chk("pin_hs_after", hsync, 1'b0);
            default: ;
        endcase
    endtask

    task automatic step(input bit req, input logic [1:0] sel);
        mode_req = req;
        mode_sel = sel;
        model_adv(req, sel);
        @(negedge clk);
        mode_req = 1'b0;
        chk($sformatf("outputs_cyc%0d", cyc), dut_vec, exp_vec());
        if (pin_on) pins();
    endtask

    task automatic hold_reset(input int n);
        reset = 1'b1;
        m_rst = 1'b1;
        model_reset();
        #1;
        chk("reset_async", dut_vec, exp_vec());
        repeat (n) begin
            @(negedge clk);
            chk("reset_hold", dut_vec, exp_vec());
        end
        reset = 1'b0;
        m_rst = 1'b0;
        cyc = 0;
        #1;
        chk("reset_release", dut_vec, exp_vec());
    endtask

    task automatic wait_pos(input int h, input int v);
        int guard = 0;
        while (!(m_h == h && m_v == v)) begin
            step(1'b0, 2'd0);
            guard++;
            if (guard > 3000) begin
                n_total++;
                $display("FAIL wait_pos timeout: at (%0d,%0d) wanted (%0d,%0d)", m_h, m_v, h, v);
                break;
            end
        end
    endtask

    task automatic wait_fe();
        int guard = 0;
        while (!at_fe()) begin
            step(1'b0, 2'd0);
            guard++;
            if (guard > 3000) begin
                n_total++;
                $display("FAIL wait_fe timeout: at (%0d,%0d)", m_h, m_v);
                break;
            end
        end
    endtask

    // DUT B: first line and a bit of real 720p timing after reset.
    initial begin
        logic [35:0] e;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("b_reset", dut_b_vec, {12'd0, 12'd0, 2'd1, 1'b0, 4'b0000, 1'b0, 4'b0000});
        rst_b = 1'b0;
        #1;
        for (int c = 0; c <= 1700; c++) begin
            bit hs, fs, ls;
            if (c > 0) @(negedge clk);
            hs = (c >= 1390) && (c <= 1429);
            fs = (c == 0);
            ls = (c % 1650) == 0;
            e = {12'(c % 1650), 12'(c / 1650), 2'd1, 1'b0, hs, 1'b0, 1'b0, fs, ls, hs, 1'b0, 1'b0, fs};
            chk($sformatf("b_cyc%0d", c), dut_b_vec, e);
        end
        b_done = 1'b1;
    end

    initial begin
        logic [1:0] rs;
        hold_reset(3);
        pin_on = 1'b1;
        repeat (400) step(1'b0, 2'd0);
        pin_on = 1'b0;
        // switch to mode 0 mid-frame
        wait_pos(4, 3);
        step(1'b1, 2'd0);
        repeat (700) step(1'b0, 2'd0);
        // two requests in one frame, latest wins
        wait_pos(2, 1);
        step(1'b1, 2'd0);
        repeat (20) step(1'b0, 2'd0);
        step(1'b1, 2'd2);
        repeat (1100) step(1'b0, 2'd0);
        // request exactly on the frame-end cycle, coerced mode 3
        wait_fe();
        step(1'b1, 2'd3);
        repeat (1200) step(1'b0, 2'd0);
        // request for the mode already running
        wait_pos(0, 2);
        step(1'b1, 2'd1);
        repeat (800) step(1'b0, 2'd0);
        // reset in the middle of a pending switch
        wait_pos(7, 1);
        step(1'b1, 2'd0);
        repeat (5) step(1'b0, 2'd0);
        hold_reset(2);
        repeat (100) step(1'b0, 2'd0);
        // random traffic
        repeat (5000) begin
            rs = 2'($urandom_range(3, 0));
            step($urandom_range(199, 0) == 0, rs);
        end
        for (int i = 0; i < 3000 && !b_done; i++) @(negedge clk);
        if (!b_done) begin
            n_total++;
            $display("FAIL b_done timeout: got 0 expected 1");
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
